// File: rtl/decode_execute_stage_if.sv
// Decode-to-execute boundary signals: decode-side instruction, writeback bypass
// port, execute hold/flush controls and the registered execute-side outputs.
interface decode_execute_stage_if #(
    parameter int N = 4,
    parameter int M = 32,
    parameter int C = 16
);
    logic         ValidD;
    logic [N-1:0] A1D, A2D, A3D;
    logic         UseA1D, UseA2D;
    logic [M-1:0] RD1D, RD2D, PCPlus8D, ImmD;
    logic [C-1:0] CtrlD;
    logic         WE3W;
    logic [N-1:0] A3W;
    logic [M-1:0] WD3W;
    logic         StallE, FlushE;

    logic         ValidE;
    logic [M-1:0] RD1E, RD2E, ImmE;
    logic [N-1:0] A1E, A2E, A3E;
    logic [C-1:0] CtrlE;
    logic         StallD;
    logic [15:0]  BubbleCount;

    modport master (
        output ValidD, A1D, A2D, A3D, UseA1D, UseA2D, RD1D, RD2D, PCPlus8D, ImmD,
               CtrlD, WE3W, A3W, WD3W, StallE, FlushE,
        input  ValidE, RD1E, RD2E, ImmE, A1E, A2E, A3E, CtrlE, StallD, BubbleCount
    );

    modport slave (
        input  ValidD, A1D, A2D, A3D, UseA1D, UseA2D, RD1D, RD2D, PCPlus8D, ImmD,
               CtrlD, WE3W, A3W, WD3W, StallE, FlushE,
        output ValidE, RD1E, RD2E, ImmE, A1E, A2E, A3E, CtrlE, StallD, BubbleCount
    );
endinterface

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with R15 substitution, writeback bypass,
// load-use hazard detection, bubble insertion and a saturating bubble counter.
module des_operand_sel #(
    parameter int N = 4,
    parameter int M = 32
) (
    input  logic [N-1:0] addr,
    input  logic [M-1:0] rd,
    input  logic [M-1:0] pc_plus8,
    input  logic         we3w,
    input  logic [N-1:0] a3w,
    input  logic [M-1:0] wd3w,
    output logic [M-1:0] op
);
    localparam logic [N-1:0] PC_REG = '1;

    // R15 is checked first, so a writeback to R15 can never win the bypass.
    always_comb begin
        op = rd;
        if (addr == PC_REG)
            op = pc_plus8;
        else if (we3w && (a3w == addr))
            op = wd3w;
    end
endmodule

module decode_execute_stage #(
    parameter int N = 4,
    parameter int M = 32,
    parameter int C = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    decode_execute_stage_if.slave  bus
);
    localparam int NSRC = 2;
    localparam logic [N-1:0] PC_REG = '1;

    logic [NSRC-1:0][N-1:0] src_addr;
    logic [NSRC-1:0][M-1:0] src_rd;
    logic [NSRC-1:0][M-1:0] src_op;
    logic [NSRC-1:0]        src_use;
    logic [NSRC-1:0]        src_hit;

    logic                   valid_e_q, valid_e_d;
    logic [C-1:0]           ctrl_e_q, ctrl_e_d;
    logic [NSRC-1:0][M-1:0] op_e_q, op_e_d;
    logic [NSRC-1:0][N-1:0] addr_e_q, addr_e_d;
    logic [M-1:0]           imm_e_q, imm_e_d;
    logic [N-1:0]           a3_e_q, a3_e_d;
    logic [15:0]            bubble_cnt_q, bubble_cnt_d;

    logic lu;
    logic bubble;

    assign src_addr = {bus.A2D, bus.A1D};
    assign src_rd   = {bus.RD2D, bus.RD1D};
    assign src_use  = {bus.UseA2D, bus.UseA1D};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        des_operand_sel #(.N(N), .M(M)) u_sel (
            .addr     (src_addr[i]),
            .rd       (src_rd[i]),
            .pc_plus8 (bus.PCPlus8D),
            .we3w     (bus.WE3W),
            .a3w      (bus.A3W),
            .wd3w     (bus.WD3W),
            .op       (src_op[i])
        );
        assign src_hit[i] = src_use[i] & (src_addr[i] == a3_e_q);
    end

    // A load in E (RegWrite & MemtoReg) whose result a valid D instruction reads.
    assign lu = valid_e_q & ctrl_e_q[0] & ctrl_e_q[1] & bus.ValidD &
                (a3_e_q != PC_REG) & (|src_hit);

    assign bus.StallD = lu | bus.StallE;

    // Flush beats an external hold; a hazard only bubbles when E is free to move.
    assign bubble = bus.FlushE | (~bus.StallE & lu);

    always_comb begin
        valid_e_d    = valid_e_q;
        ctrl_e_d     = ctrl_e_q;
        op_e_d       = op_e_q;
        addr_e_d     = addr_e_q;
        imm_e_d      = imm_e_q;
        a3_e_d       = a3_e_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            valid_e_d = 1'b0;
            ctrl_e_d  = '0;
            if (bubble_cnt_q != 16'hFFFF)
                bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else if (!bus.StallE) begin
            valid_e_d = bus.ValidD;
            ctrl_e_d  = bus.ValidD ? bus.CtrlD : '0;
            op_e_d    = src_op;
            addr_e_d  = src_addr;
            imm_e_d   = bus.ImmD;
            a3_e_d    = bus.A3D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e_q    <= 1'b0;
            ctrl_e_q     <= '0;
            op_e_q       <= '0;
            addr_e_q     <= '0;
            imm_e_q      <= '0;
            a3_e_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_e_q    <= valid_e_d;
            ctrl_e_q     <= ctrl_e_d;
            op_e_q       <= op_e_d;
            addr_e_q     <= addr_e_d;
            imm_e_q      <= imm_e_d;
            a3_e_q       <= a3_e_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ValidE      = valid_e_q;
    assign bus.CtrlE       = ctrl_e_q;
    assign bus.RD1E        = op_e_q[0];
    assign bus.RD2E        = op_e_q[1];
    assign bus.A1E         = addr_e_q[0];
    assign bus.A2E         = addr_e_q[1];
    assign bus.ImmE        = imm_e_q;
    assign bus.A3E         = a3_e_q;
    assign bus.BubbleCount = bubble_cnt_q;
endmodule

// File: tb/tb_decode_execute_stage.sv
// Randomized + directed bench for decode_execute_stage with a per-cycle
// scoreboard fed by a behavioural model of the E stage.
module tb_decode_execute_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_execute_stage_if #(.N(4), .M(32), .C(16)) bus ();
    decode_execute_stage #(.N(4), .M(32), .C(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic reset, validd, use1, use2, we, stall, flush;
        logic [3:0] a1, a2, a3, a3w;
        logic [31:0] rd1, rd2, pc8, imm, wd;
        logic [15:0] ctrl;
    } din_t;

    typedef struct {
        logic valid, rst;
        logic [15:0] ctrl, cnt;
        logic [31:0] rd1, rd2, imm;
        logic [3:0] a1, a2, a3;
    } st_t;

    typedef struct {
        st_t  e;
        logic stalld;
    } rec_t;

    rec_t sb[$];
    st_t  s;
    bit   known = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [3:0] a, input logic [31:0] rd, input din_t d);
        if (a == 4'hF) return d.pc8;
        if (d.we && d.a3w == a) return d.wd;
        return rd;
    endfunction

    function automatic logic lu_f(input st_t e, input din_t d);
        logic reads_load;
        reads_load = (d.use1 && d.a1 == e.a3) || (d.use2 && d.a2 == e.a3);
        return e.valid && e.ctrl[0] && e.ctrl[1] && d.validd && e.a3 != 4'hF && reads_load;
    endfunction

    function automatic st_t next_f(input st_t e, input din_t d);
        st_t n;
        n = e;
        if (d.reset) begin
            n = '{valid: 1'b0, rst: 1'b1, ctrl: 16'h0, cnt: 16'h0, rd1: 32'h0, rd2: 32'h0,
                  imm: 32'h0, a1: 4'h0, a2: 4'h0, a3: 4'h0};
        end else if (d.flush || (!d.stall && lu_f(e, d))) begin
            n.valid = 1'b0;
            n.ctrl  = 16'h0;
            n.rst   = 1'b0;
            n.cnt   = (e.cnt == 16'hFFFF) ? e.cnt : e.cnt + 16'd1;
        end else if (!d.stall) begin
            n.valid = d.validd;
            n.ctrl  = d.validd ? d.ctrl : 16'h0;
            n.rd1   = pick(d.a1, d.rd1, d);
            n.rd2   = pick(d.a2, d.rd2, d);
            n.imm   = d.imm;
            n.a1    = d.a1;
            n.a2    = d.a2;
            n.a3    = d.a3;
            n.rst   = 1'b0;
        end
        return n;
    endfunction

    function automatic din_t idle();
        din_t d;
        d = '{reset: 1'b0, validd: 1'b0, use1: 1'b0, use2: 1'b0, we: 1'b0, stall: 1'b0,
              flush: 1'b0, a1: 4'h0, a2: 4'h0, a3: 4'h0, a3w: 4'h0, rd1: 32'h0, rd2: 32'h0,
              pc8: 32'h0, imm: 32'h0, wd: 32'h0, ctrl: 16'h0};
        return d;
    endfunction

    function automatic logic [3:0] raddr();
        return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 6));
    endfunction

    function automatic din_t rnd();
        din_t d;
        d = idle();
        d.validd = ($urandom_range(0, 5) != 0);
        d.use1 = $urandom_range(0, 1);
        d.use2 = $urandom_range(0, 1);
        d.we = $urandom_range(0, 1);
        d.stall = ($urandom_range(0, 6) == 0);
        d.flush = ($urandom_range(0, 9) == 0);
        d.a1 = raddr(); d.a2 = raddr(); d.a3 = raddr(); d.a3w = raddr();
        d.rd1 = $urandom; d.rd2 = $urandom; d.pc8 = $urandom; d.imm = $urandom; d.wd = $urandom;
        d.ctrl = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d.ctrl[1:0] = 2'b11;
        return d;
    endfunction

    // Drive one cycle of inputs just after the edge and queue what the monitor must see.
    task automatic step(input din_t d);
        rec_t r;
        @(posedge clk);
        #1;
        reset = d.reset;
        bus.ValidD = d.validd; bus.UseA1D = d.use1; bus.UseA2D = d.use2;
        bus.A1D = d.a1; bus.A2D = d.a2; bus.A3D = d.a3;
        bus.RD1D = d.rd1; bus.RD2D = d.rd2; bus.PCPlus8D = d.pc8; bus.ImmD = d.imm;
        bus.CtrlD = d.ctrl; bus.WE3W = d.we; bus.A3W = d.a3w; bus.WD3W = d.wd;
        bus.StallE = d.stall; bus.FlushE = d.flush;
        if (known) begin
            r.e = s;
            r.stalld = d.stall | lu_f(s, d);
            sb.push_back(r);
        end
        s = next_f(s, d);
        known = known | d.reset;
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("ValidE", 32'(bus.ValidE), 32'(r.e.valid));
                chk("CtrlE", 32'(bus.CtrlE), 32'(r.e.ctrl));
                chk("BubbleCount", 32'(bus.BubbleCount), 32'(r.e.cnt));
                chk("StallD", 32'(bus.StallD), 32'(r.stalld));
                if (r.e.valid || r.e.rst) begin
                    chk("RD1E", bus.RD1E, r.e.rd1);
                    chk("RD2E", bus.RD2E, r.e.rd2);
                    chk("ImmE", bus.ImmE, r.e.imm);
                    chk("AddrE", {20'h0, bus.A1E, bus.A2E, bus.A3E}, {20'h0, r.e.a1, r.e.a2, r.e.a3});
                end
            end
        end
    end

    initial begin : stim
        din_t d, ld, use_d;
        d = idle();
        step(idle()); // drives inputs to known values before reset is applied
        d.reset = 1'b1;
        step(d);
        step(d);

        d = idle();
        d.validd = 1; d.a1 = 3; d.rd1 = 32'h11; d.a2 = 4; d.rd2 = 32'h22; d.ctrl = 16'h0001;
        d.use1 = 1; d.use2 = 1;
        step(d);
        step(idle());
        chk("load_RD1E", bus.RD1E, 32'h11);
        chk("load_RD2E", bus.RD2E, 32'h22);
        chk("load_CtrlE", 32'(bus.CtrlE), 32'h0001);
        chk("load_ValidE", 32'(bus.ValidE), 32'h1);

        d.we = 1; d.a3w = 3; d.wd = 32'hDEAD;
        step(d);
        step(idle());
        chk("bypass_RD1E", bus.RD1E, 32'hDEAD);

        d.a3w = 4'hF; d.a1 = 4'hF; d.pc8 = 32'h108; d.wd = 32'hBEEF;
        step(d);
        step(idle());
        chk("r15_RD1E", bus.RD1E, 32'h108);

        ld = idle();
        ld.validd = 1; ld.ctrl = 16'h0003; ld.a3 = 5;
        step(ld);
        use_d = idle();
        use_d.validd = 1; use_d.use2 = 1; use_d.a2 = 5; use_d.rd2 = 32'h55; use_d.ctrl = 16'h0001;
        step(use_d);
        #1;
        chk("lu_StallD", 32'(bus.StallD), 32'h1);
        step(use_d);
        chk("lu_bubble_ValidE", 32'(bus.ValidE), 32'h0);
        chk("lu_BubbleCount", 32'(bus.BubbleCount), 32'h1);
        #1;
        chk("lu_StallD_clear", 32'(bus.StallD), 32'h0);
        step(idle());
        chk("lu_reload_ValidE", 32'(bus.ValidE), 32'h1);
        chk("lu_reload_A2E", 32'(bus.A2E), 32'h5);

        d = idle();
        d.validd = 1; d.ctrl = 16'h00A5; d.imm = 32'h1234;
        step(d);
        for (int i = 0; i < 3; i++) begin
            d = rnd();
            d.stall = 1; d.flush = 0; d.reset = 0;
            step(d);
        end
        step(idle());
        chk("stall_CtrlE", 32'(bus.CtrlE), 32'h00A5);
        chk("stall_ImmE", bus.ImmE, 32'h1234);
        d = idle();
        d.stall = 1; d.flush = 1; d.validd = 1; d.ctrl = 16'h7;
        step(d);
        step(idle());
        chk("flush_stall_ValidE", 32'(bus.ValidE), 32'h0);
        chk("flush_stall_Count", 32'(bus.BubbleCount), 32'h2);

        for (int i = 0; i < 2000; i++) begin
            d = rnd();
            d.reset = ($urandom_range(0, 199) == 0);
            step(d);
        end

        d = idle();
        d.reset = 1;
        step(d);
        d = idle();
        d.flush = 1;
        for (int i = 0; i < 65537; i++) step(d);
        step(idle());
        chk("sat_BubbleCount", 32'(bus.BubbleCount), 32'hFFFF);
        d = rnd();
        d.reset = 1; d.stall = 1; d.flush = 1;
        step(d);
        step(idle());
        chk("rst_BubbleCount", 32'(bus.BubbleCount), 32'h0);
        chk("rst_ValidE", 32'(bus.ValidE), 32'h0);
        chk("rst_RD1E", bus.RD1E, 32'h0);
        step(idle());
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_execute_stage.md
# decode_execute_stage

Pipeline register between the decode stage and the execute stage of the CPU. It captures the two register-file read ports (RD1, RD2) together with the immediate, destination address and control word of the instruction in decode. It substitutes PC+8 for R15 reads, bypasses same-cycle writeback data around the register file, detects load-use hazards, and inserts bubbles on hazard or flush. A saturating counter records inserted bubbles for performance debug.

## Interface
- N, 4, register address width
- M, 32, data width
- C, 16, control word width; bit 0 = RegWrite, bit 1 = MemtoReg, bit 2 = MemWrite, remaining bits carried opaquely
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, clk, and the reset is synchronous and active-high
- ValidD  in  1  decode holds a real instruction
- A1D, A2D, A3D  in  N  source 1, source 2 and destination addresses
- UseA1D, UseA2D  in  1  instruction actually reads A1D / A2D
- RD1D, RD2D  in  M  register-file read data
- PCPlus8D  in  M  value an R15 read returns
- ImmD  in  M  extended immediate
- CtrlD  in  C  decoded control word
- WE3W, A3W, WD3W  in  1/N/M  writeback port; the same signals that drive the register file
- StallE  in  1  external hold of the execute stage
- FlushE  in  1  discard the instruction entering execute
- ValidE  out  1  execute holds a real instruction
- RD1E, RD2E, ImmE  out  M  registered operands
- A1E, A2E, A3E  out  N  registered addresses, used by forwarding
- CtrlE  out  C  registered control; all zero when ValidE=0
- StallD  out  1  hold fetch/decode (combinational)
- BubbleCount  out  16  inserted-bubble counter

## Operation
- Operand select, per source (shown for source 1; source 2 is identical):
  - A1D==4'hF: PCPlus8D.
  - Otherwise, WE3W & (A3W==A1D): WD3W (bypass).
  - Otherwise: RD1D.
  - A3W==4'hF never bypasses; R15 reads always take PCPlus8D.
- Load-use hazard:
  - LU = ValidE & CtrlE[0] & CtrlE[1] & ValidD & ((UseA1D & A1D==A3E) | (UseA2D & A2D==A3E)).
  - Not raised when A3E==4'hF.
- StallD = LU | StallE.
- Per-edge priority, highest first:
  1. reset: all outputs zero.
  2. FlushE: bubble.
  3. StallE: all E registers hold.
  4. LU: bubble.
  5. Otherwise: load.
- Bubble: ValidE=0 and CtrlE=0. Data and address registers may take any value; the bench must not check them when ValidE=0.
- Load:
  - ValidE ← ValidD.
  - CtrlE ← ValidD ? CtrlD : 0.
  - Operands, ImmE and addresses ← the selected D values.
- BubbleCount:
  - +1 on each edge that inserts a bubble through FlushE or LU.
  - Saturates at 16'hFFFF.
  - Does not change on StallE holds or on ValidD=0 loads.
  - Cleared only by reset.

## Timing
- Latency: D inputs to E outputs in 1 cycle. A held instruction reappears in E on the cycle after StallD deasserts.
- Bypass path, WD3W→RD1E/RD2E: combinational into the capture mux.
- StallD: combinational from E state and D inputs, so it is valid in the same cycle.
- LU lasts exactly one cycle: after the bubble, ValidE=0 clears it. One load-use therefore yields one bubble and one StallD cycle.
- FlushE and LU in the same cycle: a single bubble, BubbleCount +1. StallD is still asserted.
- FlushE together with StallE: flush wins.
- Reset while StallE or FlushE is high: reset wins. BubbleCount=0, StallD is recomputed from the cleared E, so StallD = StallE.
- Reset values: ValidE=0, CtrlE=0, RD1E=RD2E=ImmE=0, A1E=A2E=A3E=0, BubbleCount=0.

## Test plan
- Plain load:
  - Stimulus: A1D=3, RD1D=32'h11, A2D=4, RD2D=32'h22, ValidD=1, CtrlD=16'h0001, no writeback.
  - Next cycle: RD1E=32'h11, RD2E=32'h22, CtrlE=16'h0001, ValidE=1.
- Bypass:
  - Stimulus: WE3W=1, A3W=3, WD3W=32'hDEAD, A1D=3, stale RD1D=32'h11.
  - Response: RD1E=32'hDEAD. Repeat with A3W=4'hF, A1D=4'hF, PCPlus8D=32'h108: RD1E=32'h108.
- Load-use:
  - Stimulus: E holds a load (CtrlE=16'h0003, A3E=5); D has UseA2D=1, A2D=5.
  - Response: StallD=1 that cycle. Next edge gives ValidE=0, BubbleCount=1; the following edge loads the D instruction with StallD=0.
- Stall/flush:
  - StallE=1 for 3 cycles: E outputs unchanged, StallD=1.
  - FlushE=1 with StallE=1: ValidE=0, CtrlE=0, BubbleCount+1.
- Saturation and reset:
  - Stimulus: 65,537 consecutive FlushE cycles.
  - Response: BubbleCount=16'hFFFF. Then reset=1 for one edge gives BubbleCount=0, ValidE=0, all E outputs zero.
